// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared state encoding and CLA group size for cla_seq_ctrl
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CLA_GROUP = 4;

endpackage

// File: rtl/cla_chunk.sv
// rtl/cla_chunk.sv - combinational CHUNK-bit carry-lookahead adder slice
module cla_chunk
    import cla_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    localparam int NGRP = CHUNK / CLA_GROUP;

    if (CHUNK % CLA_GROUP != 0) begin : g_chunk_check
        $error("cla_chunk: CHUNK must be a multiple of CLA_GROUP");
    end

    logic [CHUNK-1:0] w_g;
    logic [CHUNK-1:0] w_p;
    logic [CHUNK-1:0] w_c;
    logic [NGRP:0]    w_gc;

    assign w_g     = a & b;
    assign w_p     = a ^ b;
    assign w_gc[0] = ci;

    // Each 4-bit group resolves its internal carries in two levels; groups chain via group G/P
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        logic [3:0] w_gg;
        logic [3:0] w_pg;
        logic       w_cg;
        logic       w_grp_g;
        logic       w_grp_p;

        assign w_gg = w_g[gi*CLA_GROUP +: CLA_GROUP];
        assign w_pg = w_p[gi*CLA_GROUP +: CLA_GROUP];
        assign w_cg = w_gc[gi];

        assign w_c[gi*CLA_GROUP + 0] = w_cg;
        assign w_c[gi*CLA_GROUP + 1] = w_gg[0] | (w_pg[0] & w_cg);
        assign w_c[gi*CLA_GROUP + 2] = w_gg[1] | (w_pg[1] & w_gg[0])
                                     | (w_pg[1] & w_pg[0] & w_cg);
        assign w_c[gi*CLA_GROUP + 3] = w_gg[2] | (w_pg[2] & w_gg[1])
                                     | (w_pg[2] & w_pg[1] & w_gg[0])
                                     | (w_pg[2] & w_pg[1] & w_pg[0] & w_cg);

        assign w_grp_g = w_gg[3] | (w_pg[3] & w_gg[2])
                       | (w_pg[3] & w_pg[2] & w_gg[1])
                       | (w_pg[3] & w_pg[2] & w_pg[1] & w_gg[0]);
        assign w_grp_p = &w_pg;

        assign w_gc[gi+1] = w_grp_g | (w_grp_p & w_cg);
    end

    assign s  = w_p ^ w_c;
    assign co = w_gc[NGRP];

endmodule

// File: rtl/cla_seq_ctrl.sv
// rtl/cla_seq_ctrl.sv - chunk-serial CLA adder sequencer with valid/ready handshakes (option: CLA_SUB_EN)
module cla_seq_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef CLA_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH % CHUNK != 0) begin : g_width_check
        $error("cla_seq_ctrl: WIDTH must be a multiple of CHUNK");
    end

    state_t             r_state;
    state_t             w_next;
    logic [IDXW-1:0]    r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_b_in;
    logic               w_c_in;
    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_s;
    logic               w_c;

`ifdef CLA_SUB_EN
    // Subtraction is a + ~b + 1, so the operand is inverted at capture and the carry seeded to 1
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub ? 1'b1 : cin;
    assign ovf    = r_ovf;
`else
    assign w_b_in = b;
    assign w_c_in = cin;
`endif

    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_idx == IDXW'(NCHUNK - 1));
    assign w_a_chunk = r_a[int'(r_idx)*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[int'(r_idx)*CHUNK +: CHUNK];

    cla_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a  (w_a_chunk),
        .b  (w_b_chunk),
        .ci (r_carry),
        .s  (w_s),
        .co (w_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs; in_ready is held low while reset is asserted
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) w_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand capture on accept, then one chunk per cycle LSB first with the carry held across cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_accept) begin
                r_a     <= a;
                r_b     <= w_b_in;
                r_carry <= w_c_in;
                r_idx   <= '0;
                r_sum   <= '0;
            end
        end else if (r_state == RUN) begin
            r_sum[int'(r_idx)*CHUNK +: CHUNK] <= w_s;
            r_carry <= w_c;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_c;
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) & (w_s[CHUNK-1] != r_a[WIDTH-1]);
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb/tb_cla_seq_ctrl.sv - randomized and directed self-checking bench for cla_seq_ctrl (option: CLA_SUB_EN)
module tb_cla_seq_ctrl;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int NRAND  = 1000;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef CLA_SUB_EN
    logic             sub;
    logic             ovf;
`endif

    int n_vec;
    int n_err;

    cla_seq_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef CLA_SUB_EN
        .sub       (sub),
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result: {ovf, cout, sum} from plain wide integer arithmetic
    function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                                input logic rc, input logic rs);
        logic [WIDTH:0] wide;
        longint         sa, sb, sr;
        logic           v;
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        if (rs) begin
            // a - b == a + (2^WIDTH - b); the 2^WIDTH bit is set exactly when a >= b unsigned
            wide = {1'b0, ra} + ((33'h1 << WIDTH) - {1'b0, rb});
            sr   = sa - sb;
        end else begin
            wide = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            sr   = sa + sb;
        end
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {v, wide};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                         input logic dc, input logic ds);
        a   = da;
        b   = db;
        cin = dc;
`ifdef CLA_SUB_EN
        sub = ds;
`else
        if (ds) $display("note: subtract requested in add-only build");
`endif
    endtask

    // Present operands and return just after the accept edge
    task automatic start_op(input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                            input logic dc, input logic ds);
        int w;
        drive(da, db, dc, ds);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        chk("accept_wait", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges from accept to out_valid and check the result against the reference
    task automatic wait_result(input string tag, input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                               input logic dc, input logic ds);
        int lat;
        logic [WIDTH+1:0] r;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        r = ref_op(da, db, dc, ds);
        chk({tag, "_lat"}, 64'(lat), 64'(NCHUNK));
        chk({tag, "_sum"}, 64'(sum), 64'(r[WIDTH-1:0]));
        chk({tag, "_cout"}, 64'(cout), 64'(r[WIDTH]));
`ifdef CLA_SUB_EN
        if (ds) chk({tag, "_ovf"}, 64'(ovf), 64'(r[WIDTH+1]));
`endif
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("handoff_ovalid", 64'(out_valid), 64'd0);
        chk("handoff_iready", 64'(in_ready), 64'd1);
    endtask

    logic [WIDTH+1:0] q[$];
    logic [WIDTH+1:0] exp_r;
    logic [WIDTH-1:0] ra, rb;
    logic             rc, rs, will;
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;
    int               accepts, results, cyc, last_acc;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive('0, '0, 1'b0, 1'b0);

        // Reset state
        tick();
        tick();
        chk("rst_ovalid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_iready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("init_iready", 64'(in_ready), 64'd1);

        // 1. Reset mid-RUN aborts the op
        start_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
        tick();
        chk("midrun_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("mr_ovalid", 64'(out_valid), 64'd0);
            chk("mr_busy", 64'(busy), 64'd0);
            chk("mr_sum", 64'(sum), 64'd0);
            chk("mr_cout", 64'(cout), 64'd0);
            chk("mr_iready", 64'(in_ready), 64'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("mr_release_iready", 64'(in_ready), 64'd1);
        tick();
        chk("mr_post_iready", 64'(in_ready), 64'd1);
        chk("mr_post_ovalid", 64'(out_valid), 64'd0);

        // 2. Carry out of the low chunk
        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        wait_result("t2", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        chk("t2_sum_abs", 64'(sum), 64'h0000_0100);
        handoff();

        // 3. Carry ripples through every chunk
        start_op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        wait_result("t3", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        chk("t3_cout_abs", 64'(cout), 64'd1);
        handoff();
        chk("t3_held_sum", 64'(sum), 64'd0);
        chk("t3_held_cout", 64'(cout), 64'd1);

        // 4. Stall in DONE while the input side toggles
        start_op(32'hA5A5_5A5A, 32'h1357_9BDF, 1'b0, 1'b0);
        wait_result("t4", 32'hA5A5_5A5A, 32'h1357_9BDF, 1'b0, 1'b0);
        held_sum  = sum;
        held_cout = cout;
        for (int i = 0; i < 5; i++) begin
            a        = $urandom;
            b        = $urandom;
            in_valid = ~in_valid;
            tick();
            chk("t4_sum", 64'(sum), 64'(held_sum));
            chk("t4_cout", 64'(cout), 64'(held_cout));
            chk("t4_iready", 64'(in_ready), 64'd0);
            chk("t4_ovalid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        handoff();

`ifdef CLA_SUB_EN
        // 6. Subtract mode
        start_op(32'd5, 32'd7, 1'b0, 1'b1);
        wait_result("t6a", 32'd5, 32'd7, 1'b0, 1'b1);
        chk("t6a_sum_abs", 64'(sum), 64'hFFFF_FFFE);
        chk("t6a_ovf_abs", 64'(ovf), 64'd0);
        handoff();
        start_op(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        wait_result("t6b", 32'h8000_0000, 32'd1, 1'b0, 1'b1);
        chk("t6b_sum_abs", 64'(sum), 64'h7FFF_FFFF);
        chk("t6b_ovf_abs", 64'(ovf), 64'd1);
        handoff();
`endif

        // 5. Back-to-back random ops with in_valid and out_ready held high
        ra = $urandom;
        rb = $urandom;
        rc = 1'($urandom_range(0, 1));
`ifdef CLA_SUB_EN
        rs = 1'($urandom_range(0, 1));
`else
        rs = 1'b0;
`endif
        drive(ra, rb, rc, rs);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        accepts   = 0;
        results   = 0;
        cyc       = 0;
        last_acc  = -1;
        while (results < NRAND && cyc < 20000) begin
            will = in_ready && in_valid;
            tick();
            cyc++;
            if (will) begin
                q.push_back(ref_op(ra, rb, rc, rs));
                if (last_acc >= 0) chk("t5_gap", 64'(cyc - last_acc), 64'(NCHUNK + 2));
                last_acc = cyc;
                accepts++;
                if (accepts == NRAND) in_valid = 1'b0;
                ra = $urandom;
                rb = $urandom;
                rc = 1'($urandom_range(0, 1));
`ifdef CLA_SUB_EN
                rs = 1'($urandom_range(0, 1));
`endif
                drive(ra, rb, rc, rs);
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("t5_spurious", 64'd1, 64'd0);
                end else begin
                    exp_r = q.pop_front();
                    chk("t5_sum", 64'(sum), 64'(exp_r[WIDTH-1:0]));
                    chk("t5_cout", 64'(cout), 64'(exp_r[WIDTH]));
                end
                results++;
            end
        end
        chk("t5_results", 64'(results), 64'(NRAND));
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
